// File: rtl/uart_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_arb_pkg
// Brief  : Shared types and constants for the UART bus arbiter: arbiter
//          state encoding, UART register offsets and the default error word
//          returned on a slave timeout.
// Rev    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

    // UART slave register map (byte offsets)
    localparam logic [3:0]  c_REG_DATA   = 4'h0;
    localparam logic [3:0]  c_REG_STATUS = 4'h4;
    localparam logic [3:0]  c_REG_IRQCLR = 4'h8;
    localparam logic [3:0]  c_REG_IRQSET = 4'hC;

    localparam logic [31:0] c_ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Timer width covers the full TIMEOUT range (up to 255)
    localparam int          c_TIMER_W = 8;

endpackage
`default_nettype wire

// File: rtl/uart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_bus_arbiter
// Brief  : Shares one UART slave port between master 0 (CPU) and master 1
//          (debug/loader). Round-robin arbitration; every access is issued
//          as a single-cycle uart_cs strobe so slave side effects fire once.
//          The registered UART ack (or a timeout) is returned to the winner.
//
// Ports  : clk, resetn               clock, async active-low reset
//          m{0,1}_req/addr/wdata/bytesel  master request side
//          m{0,1}_ack/rdata/err      one-cycle completion, data, timeout flag
//          uart_cs/addr/wdata/bytesel registered slave access bus
//          uart_ack/rdata            slave response (ack one cycle after cs)
//          uart_inter -> m0_irq, m0_intack -> uart_intack  IRQ passthrough
// Rev    : 1.0  initial release
// ============================================================================
module uart_bus_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = c_ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_bytesel,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_bytesel,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        uart_cs,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_wdata,
    output logic [3:0]  uart_bytesel,
    input  logic        uart_ack,
    input  logic [31:0] uart_rdata,
    input  logic        uart_inter,
    output logic        uart_intack,

    output logic        m0_irq,
    input  logic        m0_intack
);

    localparam logic [c_TIMER_W-1:0] c_TIMER_LOAD = 8'(TIMEOUT - 1);

    arb_state_t             r_state, w_state_nxt;
    logic                   r_last_grant, w_last_nxt;
    logic                   r_gnt, w_gnt_nxt;
    logic [c_TIMER_W-1:0]   r_timer, w_timer_nxt;
    logic                   r_uart_cs, w_cs_nxt;
    logic [31:0]            r_uart_addr, w_addr_nxt;
    logic [31:0]            r_uart_wdata, w_wdata_nxt;
    logic [3:0]             r_uart_bytesel, w_bytesel_nxt;
    logic                   r_m0_ack, w_m0_ack_nxt;
    logic                   r_m0_err, w_m0_err_nxt;
    logic [31:0]            r_m0_rdata, w_m0_rdata_nxt;
    logic                   r_m1_ack, w_m1_ack_nxt;
    logic                   r_m1_err, w_m1_err_nxt;
    logic [31:0]            r_m1_rdata, w_m1_rdata_nxt;

    // Round-robin choice: a lone requester wins outright, on a tie the
    // master that did not win last time is picked.
    logic w_pick;
    assign w_pick = (m0_req && m1_req) ? ~r_last_grant : m1_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= IDLE;
            r_last_grant   <= 1'b1;
            r_gnt          <= 1'b0;
            r_timer        <= '0;
            r_uart_cs      <= 1'b0;
            r_uart_addr    <= '0;
            r_uart_wdata   <= '0;
            r_uart_bytesel <= '0;
            r_m0_ack       <= 1'b0;
            r_m0_err       <= 1'b0;
            r_m0_rdata     <= '0;
            r_m1_ack       <= 1'b0;
            r_m1_err       <= 1'b0;
            r_m1_rdata     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_grant   <= w_last_nxt;
            r_gnt          <= w_gnt_nxt;
            r_timer        <= w_timer_nxt;
            r_uart_cs      <= w_cs_nxt;
            r_uart_addr    <= w_addr_nxt;
            r_uart_wdata   <= w_wdata_nxt;
            r_uart_bytesel <= w_bytesel_nxt;
            r_m0_ack       <= w_m0_ack_nxt;
            r_m0_err       <= w_m0_err_nxt;
            r_m0_rdata     <= w_m0_rdata_nxt;
            r_m1_ack       <= w_m1_ack_nxt;
            r_m1_err       <= w_m1_err_nxt;
            r_m1_rdata     <= w_m1_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last_grant;
        w_gnt_nxt      = r_gnt;
        w_timer_nxt    = r_timer;
        w_cs_nxt       = 1'b0;          // strobe only ever lasts one cycle
        w_addr_nxt     = r_uart_addr;   // bus held until the next grant
        w_wdata_nxt    = r_uart_wdata;
        w_bytesel_nxt  = r_uart_bytesel;
        w_m0_ack_nxt   = 1'b0;
        w_m0_err_nxt   = 1'b0;
        w_m0_rdata_nxt = r_m0_rdata;
        w_m1_ack_nxt   = 1'b0;
        w_m1_err_nxt   = 1'b0;
        w_m1_rdata_nxt = r_m1_rdata;

        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_gnt_nxt     = w_pick;
                    w_last_nxt    = w_pick;
                    w_cs_nxt      = 1'b1;
                    w_addr_nxt    = w_pick ? m1_addr    : m0_addr;
                    w_wdata_nxt   = w_pick ? m1_wdata   : m0_wdata;
                    w_bytesel_nxt = w_pick ? m1_bytesel : m0_bytesel;
                    w_state_nxt   = STROBE;
                end
            end
            STROBE: begin
                w_timer_nxt = c_TIMER_LOAD;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A real ack takes priority over an expiring timer
                if (uart_ack || (r_timer == '0)) begin
                    w_state_nxt = GAP;
                    if (r_gnt) begin
                        w_m1_ack_nxt   = 1'b1;
                        w_m1_err_nxt   = ~uart_ack;
                        w_m1_rdata_nxt = uart_ack ? uart_rdata : ERR_DATA;
                    end else begin
                        w_m0_ack_nxt   = 1'b1;
                        w_m0_err_nxt   = ~uart_ack;
                        w_m0_rdata_nxt = uart_ack ? uart_rdata : ERR_DATA;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            GAP: begin
                // Drain any lingering ack so it cannot complete the next access
                if (!uart_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign uart_cs      = r_uart_cs;
    assign uart_addr    = r_uart_addr;
    assign uart_wdata   = r_uart_wdata;
    assign uart_bytesel = r_uart_bytesel;
    assign m0_ack       = r_m0_ack;
    assign m0_err       = r_m0_err;
    assign m0_rdata     = r_m0_rdata;
    assign m1_ack       = r_m1_ack;
    assign m1_err       = r_m1_err;
    assign m1_rdata     = r_m1_rdata;

    // Interrupt path belongs to the CPU only and bypasses arbitration
    assign m0_irq       = uart_inter;
    assign uart_intack  = m0_intack;

endmodule
`default_nettype wire

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Shares the single UART peripheral slave port between two bus masters: the CPU (master 0) and the debug/loader port (master 1).
- Arbitrates round-robin and issues each granted access to the UART as a single-cycle chip-select strobe, so slave side effects (transmit byte, RX-buffer clear) fire exactly once.
- Waits for the UART's registered ack, returns the ack and read data to the winning master, and enforces a timeout if the slave never answers.
- Sits between the masters' peripheral decode and the UART slave; the UART interrupt line is routed to master 0 only.

Parameters:
- TIMEOUT, 16, cycles to wait for uart_ack after the strobe before aborting (range 2..255).
- ERR_DATA, 32'hDEADBEEF, read data returned to a master on timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_bytesel  in  4  master 0 byte select
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data; valid while m0_ack=1
- m0_err  out  1  high with m0_ack when the access timed out
- m1_req, m1_addr, m1_wdata, m1_bytesel, m1_ack, m1_rdata, m1_err: same as master 0
- uart_cs  out  1  UART chip select, one-cycle strobe per access
- uart_addr  out  32  registered address to the UART
- uart_wdata  out  32  registered write data
- uart_bytesel  out  4  registered byte select
- uart_ack  in  1  UART ack; registered copy of cs, one cycle late
- uart_rdata  in  32  UART read data; valid with uart_ack
- uart_inter  in  1  UART interrupt request
- uart_intack  out  1  interrupt acknowledge to the UART
- m0_irq  out  1  equals uart_inter (combinational)
- m0_intack  in  1  drives uart_intack (combinational)

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; last_grant=1, so master 0 wins the first tie.
  - uart_cs=0; uart_addr, uart_wdata, uart_bytesel all 0.
  - m*_ack=0, m*_rdata=0, m*_err=0; timer=0.
- IDLE:
  - If no request, remain in IDLE.
  - If only one master requests, grant it.
  - If both request, grant the master not equal to last_grant; update last_grant.
  - At the grant edge: latch the granted master's addr, wdata and bytesel onto the uart_* outputs, set uart_cs=1, go to STROBE.
- STROBE: lasts exactly one cycle. Clear uart_cs at the next edge, load timer=TIMEOUT-1, go to WAIT.
- WAIT:
  - If uart_ack=1: capture uart_rdata into the granted m*_rdata, pulse the granted m*_ack for one cycle with m*_err=0, go to GAP.
  - Else if timer=0: set m*_rdata=ERR_DATA, pulse m*_ack with m*_err=1, go to GAP.
  - Otherwise decrement timer.
- GAP:
  - Wait until uart_ack=0, then go to IDLE. This prevents a stale ack being credited to the next access.
  - A master may drop req in the cycle after its ack; requests sampled in GAP are ignored.
- Latency: a request seen high at edge E yields the master ack after edge E+2 (IDLE→STROBE→WAIT, ack seen in the first WAIT cycle). Minimum spacing between strobes is 4 cycles.
- uart_cs is never high for two consecutive cycles.
- m*_ack never asserts for a non-granted master.
- The outputs on the uart_* bus are held stable from grant until the next grant.
- A master dropping req mid-access (protocol violation) does not abort the access; the ack is still pulsed.
- Reset asserted mid-access returns everything to reset values immediately; the UART may have seen the strobe, and no ack is delivered.
- Interrupt path is pure passthrough: no state, unaffected by arbitration.

Decomposition:
- Shared package uart_arb_pkg:
  - state enum: IDLE, STROBE, WAIT, GAP.
  - UART register offsets: DATA=4'h0, STATUS=4'h4, IRQCLR=4'h8, IRQSET=4'hC.
  - default ERR_DATA.
- No sub-module needed. The round-robin chooser and timeout counter are small enough to stay inline.

Test Plan:
- Single write: m0_req with addr=0, wdata=0x41, bytesel=4'b0001 → uart_cs high exactly one cycle carrying those values; m0_ack after 3 cycles; UART model logs exactly one byte 0x41.
- Read: UART model returns uart_rdata=0x00000002 with ack → m1_rdata=0x2 while m1_ack=1; m1_err=0.
- Contention: m0_req and m1_req held high for 4 accesses each → grants alternate m0,m1,m0,m1…; ack pulses never overlap; no uart_cs back-to-back.
- Timeout: UART model never acks, TIMEOUT=16 → m0_ack with m0_err=1 and m0_rdata=0xDEADBEEF exactly 16 cycles after the strobe; the next request is then served normally.
- Stuck ack: hold uart_ack=1 for 5 cycles after the ack → arbiter stays in GAP and does not issue a new strobe until uart_ack=0.
- Reset mid-WAIT: assert resetn=0 asynchronously → all outputs go to 0 within the same cycle; after release, the first contention grants m0.
